// File: rtl/jtdd_snd_post.sv
// Sound post-processing: DC-blocking high-pass, serial 4.4 gain, 16-bit saturation,
// one-cycle valid strobe, sticky clip/overrun flags and a peak meter.
module jtdd_snd_post #(
  parameter int unsigned DCW = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic signed [15:0] sound,
  input  logic               sample,
  input  logic               dc_en,
  input  logic        [7:0]  gain,
  input  logic               flag_clr,
  output logic signed [15:0] snd_out,
  output logic               snd_valid,
  output logic               clip,
  output logic               overrun,
  output logic        [14:0] peak
);

  typedef enum logic [2:0] {StIdle, StDc, StMul, StSat, StOut} state_e;

  state_e state_q, state_d;

  logic        [1:0]  rst_sync_q;
  logic               ready;
  logic signed [15:0] x_q, xprev_q, pend_val_q;
  logic               pend_q;
  logic               den_q;
  logic        [7:0]  gain_q;
  logic signed [25:0] acc_q, p_q;
  logic signed [17:0] y_q;
  logic        [2:0]  bit_q;
  logic signed [15:0] snd_out_q;
  logic               valid_q, clip_q, overrun_q;
  logic        [14:0] peak_q;

  logic               capture;
  logic signed [16:0] d;
  logic signed [25:0] d_sh, acc_new, y_ext, addend;
  logic signed [17:0] y_new;
  logic signed [21:0] r;
  logic signed [15:0] sat_val;
  logic               sat_hit;
  logic        [15:0] neg_out;
  logic        [14:0] mag;
  logic        [14:0] peak_new;

  // Deassertion is synchronised; captures are held off until the second flop releases.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rst_sync_q <= 2'b00;
    else       rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign ready = rst_sync_q[1];

  assign capture = (state_q == StIdle) && ready && (pend_q || sample);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (capture) state_d = StDc;
      StDc:    state_d = StMul;
      StMul:   if (bit_q == 3'd7) state_d = StSat;
      StSat:   state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // DC blocker: acc is Q18.8; the pole is 1 - 2^-DCW.
  always_comb begin
    d       = $signed({x_q[15], x_q}) - $signed({xprev_q[15], xprev_q});
    d_sh    = {d[16], d, 8'b0};
    acc_new = acc_q + d_sh - (acc_q >>> DCW);
    y_new   = den_q ? acc_new[25:8] : {{2{x_q[15]}}, x_q};
  end

  always_comb begin
    y_ext  = {{8{y_q[17]}}, y_q};
    addend = gain_q[bit_q] ? (y_ext <<< bit_q) : '0;
  end

  always_comb begin
    r       = $signed(p_q[25:4]);
    sat_val = r[15:0];
    sat_hit = 1'b0;
    if (r > 22'sd32767) begin
      sat_val = 16'sh7fff;
      sat_hit = 1'b1;
    end else if (r < -22'sd32768) begin
      sat_val = 16'sh8000;
      sat_hit = 1'b1;
    end
  end

  // |-32768| does not fit in 15 bits, so it reads as full scale.
  always_comb begin
    neg_out = -snd_out_q;
    if (!snd_out_q[15])             mag = snd_out_q[14:0];
    else if (snd_out_q == 16'sh8000) mag = 15'h7fff;
    else                             mag = neg_out[14:0];
    peak_new = peak_q;
    if (flag_clr)         peak_new = mag;
    else if (mag > peak_q) peak_new = mag;
  end

  // Pending slot: a value consumed in IDLE can be replaced in the same cycle without overrun.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      x_q        <= '0;
      den_q      <= 1'b0;
      gain_q     <= '0;
    end else if (state_q != StIdle) begin
      if (sample) begin
        pend_q     <= 1'b1;
        pend_val_q <= sound;
      end
    end else if (capture) begin
      den_q  <= dc_en;
      gain_q <= gain;
      if (pend_q) begin
        x_q    <= pend_val_q;
        pend_q <= sample;
        if (sample) pend_val_q <= sound;
      end else begin
        x_q <= sound;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q     <= '0;
      xprev_q   <= '0;
      y_q       <= '0;
      p_q       <= '0;
      bit_q     <= '0;
      snd_out_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StDc: begin
          acc_q   <= den_q ? acc_new : '0;
          xprev_q <= x_q;
          y_q     <= y_new;
          p_q     <= '0;
          bit_q   <= '0;
        end
        StMul: begin
          p_q   <= p_q + addend;
          bit_q <= bit_q + 3'd1;
        end
        StSat: begin
          snd_out_q <= sat_val;
          valid_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sticky flags: a set event beats flag_clr in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
      peak_q    <= '0;
    end else begin
      if (state_q == StSat && sat_hit) clip_q <= 1'b1;
      else if (flag_clr)               clip_q <= 1'b0;

      if (state_q != StIdle && sample && pend_q) overrun_q <= 1'b1;
      else if (flag_clr)                         overrun_q <= 1'b0;

      if (state_q == StOut) peak_q <= peak_new;
      else if (flag_clr)    peak_q <= '0;
    end
  end

  assign snd_out   = snd_out_q;
  assign snd_valid = valid_q;
  assign clip      = clip_q;
  assign overrun   = overrun_q;
  assign peak      = peak_q;

endmodule
